circular_fifo_reader: RTL and testbench

Consumer-side engine for the team's circular FIFO. It reads the word at the FIFO read pointer, hands it to a downstream valid/ready stream through a registered output stage, and advances the FIFO read pointer through the forget-count port. It splits the word stream into fixed-length frames, marks the last word of each frame, and supports a flush that discards the unfetched remainder of the current frame.

---
 rtl/circular_fifo_pkg.sv | 42 ++++
 rtl/circular_fifo_reader.sv | 160 ++++++++++++++++
 tb/tb_circular_fifo_reader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circular_fifo_pkg.sv
// Shared definitions for the circular FIFO and its reader.
//   clog       : ceil(log2(value)), constant-foldable
//   pow2_ceil  : next power of two at or above value
//   occ_width  : occupancy/forget port width for a given buffer size
//   idx_width  : word-in-frame index width (at least 1 bit)
//   rd_state_t : reader state (RUN streams words, DROP discards a frame tail)
package circular_fifo_pkg;

    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned DROP_CNT_W  = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } rd_state_t;

    function automatic int unsigned clog(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 32'd1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned pow2_ceil(input int unsigned value);
        return 32'd1 << clog(value);
    endfunction

    // Occupancy ranges 0..P inclusive, so one extra bit over log2(P).
    function automatic int unsigned occ_width(input int unsigned buffer_size);
        return clog(pow2_ceil(buffer_size)) + 32'd1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned frame_words);
        return (clog(frame_words) < 32'd1) ? 32'd1 : clog(frame_words);
    endfunction

endpackage

// File: rtl/circular_fifo_reader.sv
// Consumer-side engine for the circular FIFO.
// Peeks the word at the FIFO read pointer, moves it into a registered
// valid/ready output stage and retires it through buf_forget_inc. The word
// stream is cut into FRAME_WORDS-long frames with m_last on each frame end.
// A flush discards the not-yet-fetched tail of the current frame.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   buf_occupancy   : words held in the FIFO (0..P)
//   buf_rdata       : word at the FIFO read pointer (combinational peek)
//   buf_forget_inc  : words the FIFO retires at this edge (combinational)
//   m_data/m_valid/m_last/m_ready : downstream stream, registered outputs
//   flush_req       : one-cycle request to drop the rest of the current frame
//   frames_sent     : frames completed downstream, wrapping
//   drop_cnt        : truncated frames, saturating
//   busy            : frame partly fetched, drop in progress, or word pending
module circular_fifo_reader
    import circular_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned BUFFER_SIZE = 16,
    parameter int unsigned FRAME_WORDS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [occ_width(BUFFER_SIZE)-1:0]     buf_occupancy,
    input  logic [DATA_WIDTH-1:0]                 buf_rdata,
    output logic [occ_width(BUFFER_SIZE)-1:0]     buf_forget_inc,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic                                  m_valid,
    output logic                                  m_last,
    input  logic                                  m_ready,
    input  logic                                  flush_req,
    output logic [FRAME_CNT_W-1:0]                frames_sent,
    output logic [DROP_CNT_W-1:0]                 drop_cnt,
    output logic                                  busy
);

    localparam int unsigned OCC_W = occ_width(BUFFER_SIZE);
    localparam int unsigned IDX_W = idx_width(FRAME_WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [OCC_W-1:0] FRAME_LEN = OCC_W'(FRAME_WORDS);

    rd_state_t               state_q, state_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic [OCC_W-1:0]        remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [FRAME_CNT_W-1:0]  frames_q, frames_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;

    logic                    handshake;
    logic                    flush_take;
    logic                    load;
    logic [OCC_W-1:0]        drop_take;
    logic [OCC_W-1:0]        forget_c;

    // State and output-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            word_idx_q  <= '0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frames_q    <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frames_q    <= frames_d;
            drop_q      <= drop_d;
        end
    end

    // Next-state, output-stage update and FIFO retire count.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frames_d    = frames_q;
        drop_d      = drop_q;
        flush_take  = 1'b0;
        load        = 1'b0;
        drop_take   = '0;
        forget_c    = '0;

        handshake = m_valid_q && m_ready;

        // Frame completion is counted on delivery, independent of state.
        if (handshake && m_last_q) begin
            frames_d = frames_q + FRAME_CNT_W'(1);
        end

        // Draining the output stage; a load below overrides this.
        if (handshake) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            RUN: begin
                // A flush only matters once part of a frame has been fetched.
                flush_take = flush_req && (word_idx_q != '0);
                load = !flush_take && (!m_valid_q || m_ready) && (buf_occupancy != '0);

                if (load) begin
                    forget_c  = OCC_W'(1);
                    m_data_d  = buf_rdata;
                    m_valid_d = 1'b1;
                    m_last_d  = (word_idx_q == LAST_IDX);
                    word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + IDX_W'(1);
                end

                if (flush_take) begin
                    state_d     = DROP;
                    remaining_d = FRAME_LEN - OCC_W'(word_idx_q);
                end
            end

            DROP: begin
                // Retire as much of the frame tail as the FIFO currently holds.
                drop_take   = (buf_occupancy < remaining_q) ? buf_occupancy : remaining_q;
                forget_c    = drop_take;
                remaining_d = remaining_q - drop_take;

                if (remaining_d == '0) begin
                    state_d    = RUN;
                    word_idx_d = '0;
                    drop_d     = (drop_q == DROP_CNT_MAX) ? drop_q : drop_q + DROP_CNT_W'(1);
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // The FIFO must not move while the reader is held in reset.
    assign buf_forget_inc = rst_n ? forget_c : '0;

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frames_sent = frames_q;
    assign drop_cnt    = drop_q;
    assign busy        = (state_q == DROP) || (word_idx_q != '0) || m_valid_q;

endmodule

// File: tb/tb_circular_fifo_reader.sv
module tb_circular_fifo_reader;
    import circular_fifo_pkg::*;

    localparam int unsigned DW    = 512;
    localparam int unsigned BS    = 16;
    localparam int unsigned FW    = 4;
    localparam int unsigned OW    = occ_width(BS);
    localparam int unsigned DEPTH = pow2_ceil(BS);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [OW-1:0]     buf_occupancy;
    logic [DW-1:0]     buf_rdata;
    logic [OW-1:0]     buf_forget_inc;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic              flush_req;
    logic [15:0]       frames_sent;
    logic [7:0]        drop_cnt;
    logic              busy;

    always #5 clk = ~clk;

    circular_fifo_reader #(
        .DATA_WIDTH (DW),
        .BUFFER_SIZE(BS),
        .FRAME_WORDS(FW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .buf_occupancy (buf_occupancy),
        .buf_rdata     (buf_rdata),
        .buf_forget_inc(buf_forget_inc),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .flush_req     (flush_req),
        .frames_sent   (frames_sent),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    // FIFO contents as seen by the reader, plus delivered/expected words.
    logic [DW-1:0] fifo[$];
    logic [DW:0]   got[$];
    logic [DW:0]   exp_q[$];
    int            fg_log[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame position, pending output word, drop progress.
    bit            mv;
    bit            ml;
    logic [DW-1:0] md;
    int            pos;
    bit            dropping;
    int            drop_left;
    int            frames;
    int            drops;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] dw(input int n);
        return {16{32'hD000_0000 + 32'(n)}};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive_fifo();
        buf_occupancy = OW'(fifo.size());
        buf_rdata     = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        if (fifo.size() < int'(DEPTH)) fifo.push_back(w);
        drive_fifo();
    endtask

    task automatic model_reset();
        mv = 1'b0; ml = 1'b0; md = '0; pos = 0;
        dropping = 1'b0; drop_left = 0; frames = 0; drops = 0;
    endtask

    task automatic expect_word(input int n, input bit last);
        exp_q.push_back({last, dw(n)});
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, DW'(got.size()), DW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check({tag, "_data"}, got[i][DW-1:0], exp_q[i][DW-1:0]);
            check({tag, "_last"}, DW'(got[i][DW]), DW'(exp_q[i][DW]));
        end
        got.delete();
        exp_q.delete();
        fg_log.delete();
    endtask

    // One clock: compare DUT to the model mid-cycle, advance model, let the FIFO retire words.
    task automatic cycle();
        int occ, ef, k, dut_fg;
        bit hs, fl, ld;
        @(negedge clk);
        occ = fifo.size();
        hs  = mv && m_ready;
        check("m_valid", DW'(m_valid), DW'(mv));
        check("m_last", DW'(m_last), DW'(ml));
        if (mv) check("m_data", m_data, md);
        check("busy", DW'(busy), DW'(dropping || pos != 0 || mv));
        check("frames_sent", DW'(frames_sent), DW'(frames[15:0]));
        check("drop_cnt", DW'(drop_cnt), DW'(drops));
        if (m_valid && m_ready) got.push_back({m_last, m_data});

        ef = 0;
        if (hs && ml) frames++;
        if (!dropping) begin
            fl = flush_req && pos != 0;
            ld = !fl && (!mv || m_ready) && occ > 0;
            if (ld) begin
                ef = 1;
                md = fifo[0];
                mv = 1'b1;
                ml = (pos == int'(FW) - 1);
                pos = (pos + 1) % int'(FW);
            end else if (hs) begin
                mv = 1'b0;
                ml = 1'b0;
            end
            if (fl) begin
                dropping  = 1'b1;
                drop_left = int'(FW) - pos;
            end
        end else begin
            k = (occ < drop_left) ? occ : drop_left;
            ef = k;
            drop_left -= k;
            if (hs) begin
                mv = 1'b0;
                ml = 1'b0;
            end
            if (drop_left == 0) begin
                dropping = 1'b0;
                pos = 0;
                if (drops < 255) drops++;
            end
        end
        check("forget", DW'(buf_forget_inc), DW'(ef));
        dut_fg = int'(buf_forget_inc);
        fg_log.push_back(dut_fg);

        @(posedge clk);
        for (int i = 0; i < dut_fg && fifo.size() != 0; i++) void'(fifo.pop_front());
        #1;
        drive_fifo();
        flush_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1;
        int f0;

        rst_n = 1'b0;
        m_ready = 1'b0;
        flush_req = 1'b0;
        buf_occupancy = '0;
        buf_rdata = '0;
        model_reset();

        // Reset held with words waiting in the FIFO.
        for (int i = 0; i < 5; i++) push(dw(100 + i));
        @(negedge clk);
        check("rst_valid", DW'(m_valid), DW'(0));
        check("rst_last", DW'(m_last), DW'(0));
        check("rst_data", m_data, '0);
        check("rst_forget", DW'(buf_forget_inc), DW'(0));
        check("rst_frames", DW'(frames_sent), DW'(0));
        check("rst_drop", DW'(drop_cnt), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        fifo.delete();
        drive_fifo();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming two full frames back-to-back.
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(dw(i));
        repeat (10) cycle();
        n1 = 0;
        for (int i = 0; i < 8; i++) if (fg_log[i] == 1) n1++;
        check("stream_forget_run", DW'(n1), DW'(8));
        check("stream_frames", DW'(frames_sent), DW'(2));
        check("stream_busy", DW'(busy), DW'(0));
        for (int i = 0; i < 8; i++) expect_word(i, i % 4 == 3);
        check_stream("stream");

        // Backpressure: only one word may be fetched while stalled.
        m_ready = 1'b0;
        for (int i = 10; i < 13; i++) push(dw(i));
        repeat (4) cycle();
        n1 = 0;
        foreach (fg_log[i]) n1 += fg_log[i];
        check("bp_forget_total", DW'(n1), DW'(1));
        check("bp_hold_data", m_data, dw(10));
        check("bp_hold_valid", DW'(m_valid), DW'(1));
        m_ready = 1'b1;
        repeat (4) cycle();
        push(dw(13));
        repeat (3) cycle();
        expect_word(10, 0); expect_word(11, 0); expect_word(12, 0); expect_word(13, 1);
        check_stream("bp");

        // Mid-frame flush after two words of an eight-word backlog.
        for (int i = 20; i < 28; i++) push(dw(i));
        cycle();
        cycle();
        check("mf_occ", DW'(buf_occupancy), DW'(6));
        flush_req = 1'b1;
        cycle();
        cycle();
        check("mf_fg_flush", DW'(fg_log[2]), DW'(0));
        check("mf_fg_drop", DW'(fg_log[3]), DW'(2));
        check("mf_drop_cnt", DW'(drop_cnt), DW'(1));
        repeat (6) cycle();
        expect_word(20, 0); expect_word(21, 0);
        expect_word(24, 0); expect_word(25, 0); expect_word(26, 0); expect_word(27, 1);
        check_stream("mf");

        // Flush that runs out of FIFO words and waits for more.
        push(dw(30)); push(dw(31));
        cycle();
        flush_req = 1'b1;
        cycle();
        cycle();
        repeat (3) cycle();
        push(dw(32)); push(dw(33)); push(dw(34));
        cycle();
        check("sf_fg_flush", DW'(fg_log[1]), DW'(0));
        check("sf_fg_first", DW'(fg_log[2]), DW'(1));
        check("sf_fg_wait", DW'(fg_log[3] + fg_log[4] + fg_log[5]), DW'(0));
        check("sf_fg_rest", DW'(fg_log[6]), DW'(2));
        check("sf_drop_cnt", DW'(drop_cnt), DW'(2));
        repeat (3) cycle();
        push(dw(35)); push(dw(36)); push(dw(37));
        repeat (5) cycle();
        expect_word(30, 0); expect_word(34, 0); expect_word(35, 0); expect_word(36, 0); expect_word(37, 1);
        check_stream("sf");

        // Flush on a frame boundary is ignored; then drain a full FIFO.
        flush_req = 1'b1;
        cycle();
        check("bd_fg", DW'(fg_log[0]), DW'(0));
        check("bd_drop_cnt", DW'(drop_cnt), DW'(2));
        check("bd_busy", DW'(busy), DW'(0));
        for (int i = 0; i < 16; i++) push(dw(40 + i));
        check("full_occ", DW'(buf_occupancy), DW'(16));
        f0 = int'(frames_sent);
        repeat (20) cycle();
        check("full_frames", DW'(frames_sent), DW'(16'(f0 + 4)));
        fg_log.delete();
        for (int i = 0; i < 16; i++) expect_word(40 + i, i % 4 == 3);
        check_stream("full");

        // Asynchronous reset in the middle of a frame.
        push(dw(50)); push(dw(51));
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", DW'(m_valid), DW'(0));
        check("mr_busy", DW'(busy), DW'(0));
        check("mr_forget", DW'(buf_forget_inc), DW'(0));
        check("mr_frames", DW'(frames_sent), DW'(0));
        check("mr_drop", DW'(drop_cnt), DW'(0));
        fifo.delete();
        drive_fifo();
        model_reset();
        got.delete();
        fg_log.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 256 truncated frames: drop_cnt must stick at 255.
        m_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 4; i++) push(dw(1000 + n * 4 + i));
            cycle();
            flush_req = 1'b1;
            cycle();
            cycle();
        end
        repeat (2) cycle();
        check("sat_drop_cnt", DW'(drop_cnt), DW'(255));
        got.delete();
        fg_log.delete();

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            int np;
            np = (c < 1500) ? $urandom_range(0, 2) : $urandom_range(0, 1);
            for (int i = 0; i < np; i++) push(rand_word());
            m_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush_req = ($urandom_range(0, 9) == 0);
            cycle();
        end
        m_ready = 1'b1;
        repeat (40) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
